// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU pixel writer and the frame-buffer readback engine:
// display geometry, ping-pong buffer bases, readback register map, STATUS bit
// positions and the readback FSM encoding. No ports; imported with gpu_pkg::*.
package gpu_pkg;

  // Display geometry; H_DISP is the address stride between lines.
  localparam int H_DISP = 1024;
  localparam int V_DISP = 600;

  // Frame-buffer bases in SDRAM word-address space.
  localparam logic [20:0] PING_PONG_0 = 21'h000000;
  localparam logic [20:0] PING_PONG_1 = 21'h100000;

  // Readback register map (bus word index).
  localparam logic [7:0] REG_X_POS     = 8'd0;
  localparam logic [7:0] REG_Y_POS     = 8'd1;
  localparam logic [7:0] REG_LEN       = 8'd2;
  localparam logic [7:0] REG_ENABLE    = 8'd3;
  localparam logic [7:0] REG_STATUS    = 8'd4;
  localparam logic [7:0] REG_COUNT     = 8'd5;
  localparam logic [7:0] REG_PING_PONG = 8'd6;
  localparam logic [7:0] REG_BUF_BASE  = 8'd16;

  // STATUS register bit positions.
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TIMEOUT  = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } rb_state_t;

  // Merge a bus write into a 32-bit register honouring per-byte lane enables.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_readback_buffer.sv
// Capture buffer for the readback engine: DEPTH x 24-bit, one write port and one
// read port, registered read (data appears one clock after raddr).
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. No reset: contents undefined.
module gpu_readback_buffer #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [23:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   rdata
);

  logic [23:0] mem [DEPTH];

  // Read-before-write when both ports hit the same word in one cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gpu_readback.sv
// Frame-buffer readback engine: on CPU start, issues one SDRAM read burst from pixel
// (X,Y) of the back buffer and captures returned pixels into a local buffer.
// Ports: byte-lane register bus (addrIn/sizeDecode/dataIn write, addrOut/dataOut read,
// 1-cycle read latency); SDRAM read port (rd_load/rd_addr/rd_len out, rd_valid/rd_data/rd_done in).
module gpu_readback
  import gpu_pkg::*;
#(
  parameter int BUFF_DEPTH = 128,
  parameter int ADDR_W     = 21,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        addrIn,
  input  logic [7:0]        addrOut,
  input  logic [3:0]        sizeDecode,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              rd_load,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_len,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  input  logic              rd_done
);

  localparam int BUF_AW  = $clog2(BUFF_DEPTH);
  localparam int CNT_W   = $clog2(BUFF_DEPTH + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int BUF_END = 16 + BUFF_DEPTH;

  // ---------------------------------------------------------------- registers
  logic [31:0]      x_pos;
  logic [31:0]      y_pos;
  logic [23:0]      len;
  logic             enable;
  logic             ping_pong;

  logic [CNT_W-1:0] count;
  logic [TMO_W-1:0] tcnt;
  logic             done_f;
  logic             tmo_f;
  logic             ovf_f;

  rb_state_t        state;
  rb_state_t        state_nxt;

  logic             start;
  logic             latch;
  logic             capture;
  logic             drop;
  logic             tmo_hit;

  logic [31:0]      pix_off;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_calc;
  logic [23:0]      len_clip;
  logic             busy;
  logic [3:0]       status;

  logic [31:0]      reg_word;
  logic [31:0]      reg_q;
  logic             sel_buf_q;
  logic             in_buf;
  logic [BUF_AW-1:0] buf_raddr;
  logic [23:0]      buf_q;

  // Only the low 16 bits of X/Y and the pixel bits of the returned word matter.
  logic             unused_bits;
  assign unused_bits = ^{x_pos[31:16], y_pos[31:16], rd_data[7:0]};

  // ------------------------------------------------------- register writes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_pos     <= '0;
      y_pos     <= '0;
      len       <= '0;
      enable    <= 1'b0;
      ping_pong <= 1'b0;
    end else if (sizeDecode != 4'b0000) begin
      case (addrIn)
        REG_X_POS:     x_pos <= byte_merge(x_pos, dataIn, sizeDecode);
        REG_Y_POS:     y_pos <= byte_merge(y_pos, dataIn, sizeDecode);
        REG_LEN:       len   <= 24'(byte_merge({8'h00, len}, dataIn, sizeDecode));
        REG_ENABLE:    if (sizeDecode[0]) enable <= dataIn[0];
        REG_PING_PONG: if (sizeDecode[0]) ping_pong <= dataIn[0];
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------- burst parameters
  // The read targets the buffer the pixel writer is drawing into, hence the
  // inverted sense of PING_PONG relative to the base names.
  assign base      = ping_pong ? ADDR_W'(PING_PONG_0) : ADDR_W'(PING_PONG_1);
  assign pix_off   = {16'h0000, x_pos[15:0]} + (32'(y_pos[15:0]) * 32'(H_DISP));
  assign addr_calc = base | pix_off[ADDR_W-1:0];
  assign len_clip  = (len > 24'(BUFF_DEPTH)) ? 24'(BUFF_DEPTH) : len;

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        latch     = 1'b1;
        state_nxt = (len_clip == 24'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        capture = rd_valid && (count < CNT_W'(BUFF_DEPTH));
        drop    = rd_valid && (count >= CNT_W'(BUFF_DEPTH));
        // A word arriving with rd_done is still stored (capture above).
        if (rd_done) begin
          state_nxt = S_DONE;
        end else if (tcnt == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_load <= 1'b0;
      rd_addr <= '0;
      rd_len  <= '0;
      count   <= '0;
      tcnt    <= '0;
      done_f  <= 1'b0;
      tmo_f   <= 1'b0;
      ovf_f   <= 1'b0;
    end else begin
      rd_load <= 1'b0;
      if (start) begin
        count  <= '0;
        tcnt   <= '0;
        done_f <= 1'b0;
        tmo_f  <= 1'b0;
        ovf_f  <= 1'b0;
      end
      // rd_addr/rd_len become visible together with the rd_load pulse and
      // stay put until the next burst is latched.
      if (latch) begin
        rd_addr <= addr_calc;
        rd_len  <= len_clip;
        rd_load <= (len_clip != 24'd0);
      end
      if (state == S_WAIT) tcnt <= tcnt + TMO_W'(1);
      if (capture) count <= count + CNT_W'(1);
      if (drop)    ovf_f <= 1'b1;
      if (tmo_hit) tmo_f <= 1'b1;
      if ((state != S_DONE) && (state_nxt == S_DONE)) done_f <= 1'b1;
    end
  end

  assign busy = (state == S_LOAD) || (state == S_WAIT);

  always_comb begin
    status              = 4'b0000;
    status[ST_BUSY]     = busy;
    status[ST_DONE]     = done_f;
    status[ST_TIMEOUT]  = tmo_f;
    status[ST_OVERFLOW] = ovf_f;
  end

  // ---------------------------------------------------------- capture RAM
  gpu_readback_buffer #(
    .DEPTH (BUFF_DEPTH),
    .AW    (BUF_AW)
  ) u_buffer (
    .clk   (clk),
    .we    (capture),
    .waddr (count[BUF_AW-1:0]),
    .wdata (rd_data[31:8]),
    .raddr (buf_raddr),
    .rdata (buf_q)
  );

  // -------------------------------------------------------------- bus read
  assign in_buf    = (addrOut >= REG_BUF_BASE) && (int'(addrOut) < BUF_END);
  assign buf_raddr = BUF_AW'(addrOut - REG_BUF_BASE);

  always_comb begin
    reg_word = '0;
    case (addrOut)
      REG_X_POS:     reg_word = x_pos;
      REG_Y_POS:     reg_word = y_pos;
      REG_LEN:       reg_word = {8'h00, len};
      REG_ENABLE:    reg_word = {31'b0, enable};
      REG_STATUS:    reg_word = {28'b0, status};
      REG_COUNT:     reg_word = 32'(count);
      REG_PING_PONG: reg_word = {31'b0, ping_pong};
      default:       reg_word = '0;
    endcase
  end

  // Register words and the RAM output are both one clock behind addrOut; the
  // registered select picks between them so buffer reads keep 1-cycle latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_q     <= '0;
      sel_buf_q <= 1'b0;
    end else begin
      reg_q     <= reg_word;
      sel_buf_q <= in_buf;
    end
  end

  assign dataOut = sel_buf_q ? {8'h00, buf_q} : reg_q;

endmodule

// File: tb/tb_gpu_readback.sv
// Scoreboard bench for gpu_readback: stimulus pushes expected bus-read words and
// expected burst descriptors into queues; monitors pop and compare when the DUT
// presents a read result or an rd_load pulse.
module tb_gpu_readback;

  localparam int DEPTH   = 128;
  localparam int TMO     = 65535;
  localparam int ST_IDX  = 4;
  localparam int CNT_IDX = 5;

  logic        clk;
  logic        rstn;
  logic [7:0]  addrIn;
  logic [7:0]  addrOut;
  logic [3:0]  sizeDecode;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        rd_load;
  logic [20:0] rd_addr;
  logic [23:0] rd_len;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_done;

  gpu_readback #(.BUFF_DEPTH(DEPTH), .ADDR_W(21), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .addrIn     (addrIn),
    .addrOut    (addrOut),
    .sizeDecode (sizeDecode),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .rd_load    (rd_load),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_done    (rd_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct { logic [31:0] v; string nm; } rd_exp_t;
  typedef struct { logic [20:0] a; logic [23:0] l; } ld_exp_t;
  rd_exp_t exp_rd_q[$];
  ld_exp_t exp_ld_q[$];
  logic    rd_req = 1'b0;
  logic    rd_pend = 1'b0;
  logic [20:0] last_addr = '0;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      rd_exp_t e;
      chk("read_expected", 32'(exp_rd_q.size() != 0), 32'd1);
      if (exp_rd_q.size() != 0) begin
        e = exp_rd_q.pop_front();
        chk(e.nm, dataOut, e.v);
      end
    end
  end

  always @(negedge clk) begin
    if (rd_load) begin
      ld_exp_t e;
      chk("rd_load_expected", 32'(exp_ld_q.size() != 0), 32'd1);
      if (exp_ld_q.size() != 0) begin
        e = exp_ld_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(e.a));
        chk("rd_len", 32'(rd_len), 32'(e.l));
        last_addr = e.a;
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, required finish within 95000 cycles");
    $fatal(1);
  end

  // ------------------------------------------------------- reference model
  int          m_x, m_y, m_len, m_pp;
  int          m_count;
  bit          m_ovf, m_tmo;
  logic [23:0] m_buf [DEPTH];

  function automatic int clip_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [20:0] exp_addr();
    int b;
    b = (m_pp != 0) ? 0 : 'h100000;
    return 21'(b + (m_x % 65536) + (m_y % 65536) * 1024);
  endfunction

  function automatic logic [31:0] exp_status(input bit busy);
    return {28'b0, m_ovf, m_tmo, !busy, busy};
  endfunction

  // ---------------------------------------------------------- bus helpers
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    addrIn = a; dataIn = d; sizeDecode = be;
    @(negedge clk);
    sizeDecode = 4'b0000;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] v, input string nm);
    rd_exp_t e;
    e.v = v; e.nm = nm;
    exp_rd_q.push_back(e);
    addrOut = a; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic set_regs(input int x, input int y, input int l, input int pp);
    m_x = x; m_y = y; m_len = l; m_pp = pp;
    bus_write(8'd0, 32'(x), 4'hF);
    bus_write(8'd1, 32'(y), 4'hF);
    bus_write(8'd2, 32'(l), 4'hF);
    bus_write(8'd6, 32'(pp), 4'hF);
  endtask

  // Write ENABLE and, for a nonzero length, expect rd_load two cycles later.
  task automatic start_burst();
    int k;
    m_count = 0; m_ovf = 0; m_tmo = 0;
    if (m_len != 0) begin
      ld_exp_t e;
      e.a = exp_addr(); e.l = 24'(clip_len(m_len));
      exp_ld_q.push_back(e);
    end
    bus_write(8'd3, 32'd1, 4'hF);
    if (m_len != 0) begin
      k = 0;
      while (!rd_load && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("load_latency", 32'(k), 32'd2);
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic end_burst();
    bus_write(8'd3, 32'd0, 4'hF);
    @(negedge clk);
  endtask

  // Return n words with random gaps; rd_done either after or with the last word.
  task automatic respond(input int n, input bit give_done, input bit coincide,
                         input bit rnd, input logic [31:0] d0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rd_valid = 1'b1;
      rd_data  = rnd ? $urandom : d0 + 32'(i << 8);
      if (m_count < DEPTH) begin
        m_buf[m_count] = rd_data[31:8];
        m_count++;
      end else begin
        m_ovf = 1;
      end
      if (give_done && coincide && i == n - 1) rd_done = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
      rd_done  = 1'b0;
    end
    if (give_done && !(coincide && n > 0)) begin
      rd_done = 1'b1;
      @(negedge clk);
      rd_done = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_results(input bit all_words);
    bus_read(8'(CNT_IDX), 32'(m_count), "count");
    bus_read(8'(ST_IDX), exp_status(0), "status");
    for (int i = 0; i < m_count; i++) begin
      if (all_words || i == 0 || i == m_count - 1 || $urandom_range(0, 7) == 0)
        bus_read(8'(16 + i), {8'h00, m_buf[i]}, "buffer_word");
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int n, l;
    logic [20:0] held;
    rstn = 1'b1; addrIn = '0; addrOut = '0; sizeDecode = '0; dataIn = '0;
    rd_valid = 1'b0; rd_data = '0; rd_done = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dataOut", dataOut, 32'd0);
    chk("reset_rd_load", 32'(rd_load), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_rd_len", 32'(rd_len), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) bus_read(8'(i), 32'd0, "reset_reg");

    // Byte-lane writes, read-only and reserved locations.
    bus_write(8'd0, 32'h12345678, 4'hF);
    bus_write(8'd0, 32'hFFFFFFFF, 4'b0101);
    bus_read(8'd0, 32'h12FF56FF, "x_pos_bytelane");
    bus_write(8'd2, 32'hFFFFFFFF, 4'hF);
    bus_read(8'd2, 32'h00FFFFFF, "len_width");
    bus_write(8'd7, 32'hDEADBEEF, 4'hF);
    bus_write(8'd4, 32'hFFFFFFFF, 4'hF);
    bus_write(8'd5, 32'hFFFFFFFF, 4'hF);
    bus_read(8'd7, 32'd0, "reserved_ro");
    bus_read(8'd4, 32'd0, "status_ro");
    bus_read(8'd5, 32'd0, "count_ro");

    // Basic burst from back buffer 1.
    set_regs(10, 2, 4, 0);
    start_burst();
    respond(4, 1, 0, 0, 32'hAABBCC00);
    bus_read(8'd16, 32'h00AABBCC, "first_pixel");
    bus_read(8'(ST_IDX), 32'h2, "status_done");
    check_results(1);
    end_burst();

    // Overflow: length clipped, extra words dropped.
    set_regs(0, 0, 300, 1);
    start_burst();
    respond(DEPTH + 2, 1, 0, 1, 32'd0);
    bus_read(8'(ST_IDX), 32'hA, "status_overflow");
    check_results(1);
    bus_read(8'(16 + DEPTH), 32'd0, "beyond_buffer");
    bus_read(8'd255, 32'd0, "top_index");
    end_burst();

    // Zero length: straight to done, no rd_load.
    set_regs(5, 5, 0, 0);
    start_burst();
    bus_read(8'(ST_IDX), 32'h2, "len0_status");
    end_burst();

    // rd_valid coinciding with rd_done, then restart with mid-burst register write.
    set_regs(100, 7, 5, 1);
    start_burst();
    respond(5, 1, 1, 1, 32'd0);
    check_results(1);
    end_burst();
    start_burst();
    held = last_addr;
    bus_read(8'(ST_IDX), 32'h1, "restart_busy");
    bus_read(8'(CNT_IDX), 32'd0, "restart_count");
    m_x = 77;
    bus_write(8'd0, 32'd77, 4'hF);
    respond(3, 1, 0, 1, 32'd0);
    check_results(1);
    chk("rd_addr_hold", 32'(rd_addr), 32'(held));
    end_burst();
    start_burst();
    respond(1, 1, 0, 1, 32'd0);
    check_results(1);
    end_burst();

    // Timeout: responder never finishes.
    set_regs(1, 1, 4, 0);
    start_burst();
    repeat (TMO - 4) @(negedge clk);
    bus_read(8'(ST_IDX), 32'h1, "tmo_still_busy");
    repeat (8) @(negedge clk);
    m_tmo = 1;
    bus_read(8'(ST_IDX), 32'h6, "tmo_status");
    bus_read(8'(CNT_IDX), 32'd0, "tmo_count");
    end_burst();

    // Reset mid-WAIT after two of eight words.
    set_regs(3, 4, 8, 1);
    start_burst();
    respond(2, 0, 0, 1, 32'd0);
    rstn = 1'b0;
    #1;
    chk("midrst_rd_load", 32'(rd_load), 32'd0);
    chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
    chk("midrst_rd_len", 32'(rd_len), 32'd0);
    chk("midrst_dataOut", dataOut, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus_read(8'(ST_IDX), 32'd0, "midrst_status");
    bus_read(8'(CNT_IDX), 32'd0, "midrst_count");
    bus_read(8'd2, 32'd0, "midrst_len");
    repeat (3) begin
      rd_valid = 1'b1; rd_data = $urandom;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    bus_read(8'(CNT_IDX), 32'd0, "idle_valid_count");
    bus_read(8'(ST_IDX), 32'd0, "idle_valid_status");

    // Randomized bursts.
    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(0, 9);
      if (l == 0)      l = 0;
      else if (l < 3)  l = $urandom_range(DEPTH + 1, 400);
      else             l = $urandom_range(1, DEPTH);
      set_regs($urandom_range(0, 1023), $urandom_range(0, 599), l, $urandom_range(0, 1));
      start_burst();
      if (l != 0) begin
        n = $urandom_range((clip_len(l) > 2) ? clip_len(l) - 2 : 0, clip_len(l) + 3);
        respond(n, 1, 1'($urandom_range(0, 1)), 1, 32'd0);
      end
      check_results(0);
      end_burst();
    end

    repeat (3) @(negedge clk);
    chk("sb_drain_reads", 32'(exp_rd_q.size()), 32'd0);
    chk("sb_drain_loads", 32'(exp_ld_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
